// File: rtl/tracer_trace_accum.sv
// Per-ROI trace accumulator: loads a 16x16 contour mask around a latched ROI center,
// then sums masked pixels in a two-stage pipeline and latches the sum on frame_end.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | no mask loaded since reset; pixels dropped
// ST_LOAD  | contour bits being written into mask, ptr 0..255
// ST_ARMED | mask complete; in-window masked pixels accumulate
module tracer_trace_accum #(
    parameter int WIN   = 16,
    parameter int PIX_W = 8
) (
    input  logic             s_axi_aclk,
    input  logic             s_axi_aresetn,
    input  logic             load_center,
    input  logic [7:0]       center_row,
    input  logic [8:0]       center_col,
    input  logic             load_contour,
    input  logic             contour_data,
    input  logic             pix_valid,
    input  logic [7:0]       pix_row,
    input  logic [8:0]       pix_col,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             frame_end,
    input  logic             store_trace,
    output logic [15:0]      acc_trace,
    output logic             trace_valid,
    output logic             trace_overrun,
    output logic             mask_ready
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ARMED} state_e;

    state_e               state_q;
    logic [7:0]           center_row_q;
    logic [8:0]           center_col_q;
    logic [WIN*WIN-1:0]   mask_q;
    logic [7:0]           ptr_q;
    logic                 mask_ready_q;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q      <= ST_IDLE;
            center_row_q <= '0;
            center_col_q <= '0;
            mask_q       <= '0;
            ptr_q        <= '0;
            mask_ready_q <= 1'b0;
        end else if (load_center) begin
            state_q      <= ST_LOAD;
            center_row_q <= center_row;
            center_col_q <= center_col;
            mask_q       <= '0;
            ptr_q        <= '0;
            mask_ready_q <= 1'b0;
        end else if (state_q == ST_LOAD && load_contour) begin
            mask_q[ptr_q] <= contour_data;
            ptr_q         <= ptr_q + 8'd1;
            if (ptr_q == 8'd255) begin
                state_q      <= ST_ARMED;
                mask_ready_q <= 1'b1;
            end
        end
    end

    // Offsets biased by +8 so the window spans 0..15; negative results never wrap in.
    logic signed [9:0]  dr;
    logic signed [10:0] dc;
    logic               in_win;

    assign dr = $signed({2'b00, pix_row}) - $signed({2'b00, center_row_q}) + 10'sd8;
    assign dc = $signed({2'b00, pix_col}) - $signed({2'b00, center_col_q}) + 11'sd8;
    assign in_win = ~dr[9] & (dr[8:4] == 5'd0) & ~dc[10] & (dc[9:4] == 6'd0);

    logic             s1_hit_q;
    logic [7:0]       s1_idx_q;
    logic [PIX_W-1:0] s1_data_q;
    logic             s1_fe_q;
    logic [15:0]      sum_q;
    logic [15:0]      sum_nxt;
    logic [15:0]      acc_q;
    logic             valid_q;
    logic             overrun_q;

    assign sum_nxt = sum_q + ((s1_hit_q && mask_q[s1_idx_q]) ? 16'(s1_data_q) : 16'd0);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s1_hit_q  <= 1'b0;
            s1_idx_q  <= '0;
            s1_data_q <= '0;
            s1_fe_q   <= 1'b0;
            sum_q     <= '0;
            acc_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (load_center) begin
            // Flush: in-flight pixels and a pending frame_end are discarded.
            s1_hit_q <= 1'b0;
            s1_fe_q  <= 1'b0;
            sum_q    <= '0;
            if (store_trace) valid_q <= 1'b0;
        end else begin
            s1_hit_q  <= pix_valid && in_win && (state_q == ST_ARMED);
            s1_idx_q  <= {dr[3:0], dc[3:0]};
            s1_data_q <= pix_data;
            s1_fe_q   <= frame_end;
            if (s1_fe_q) begin
                acc_q   <= sum_nxt;
                sum_q   <= '0;
                valid_q <= 1'b1;
                if (valid_q && !store_trace) overrun_q <= 1'b1;
            end else begin
                sum_q <= sum_nxt;
                if (store_trace) valid_q <= 1'b0;
            end
        end
    end

    assign acc_trace     = acc_q;
    assign trace_valid   = valid_q;
    assign trace_overrun = overrun_q;
    assign mask_ready    = mask_ready_q;

endmodule

// File: tb/tb_tracer_trace_accum.sv
// Directed bench for tracer_trace_accum: mask load, masked sums, edge clipping,
// overrun/collision, restart and async reset.
module tb_tracer_trace_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_center = 1'b0;
    logic [7:0]  center_row = '0;
    logic [8:0]  center_col = '0;
    logic        load_contour = 1'b0;
    logic        contour_data = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_row = '0;
    logic [8:0]  pix_col = '0;
    logic [7:0]  pix_data = '0;
    logic        frame_end = 1'b0;
    logic        store_trace = 1'b0;
    logic [15:0] acc_trace;
    logic        trace_valid;
    logic        trace_overrun;
    logic        mask_ready;

    int tests = 0;
    int fails = 0;

    tracer_trace_accum dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .load_center   (load_center),
        .center_row    (center_row),
        .center_col    (center_col),
        .load_contour  (load_contour),
        .contour_data  (contour_data),
        .pix_valid     (pix_valid),
        .pix_row       (pix_row),
        .pix_col       (pix_col),
        .pix_data      (pix_data),
        .frame_end     (frame_end),
        .store_trace   (store_trace),
        .acc_trace     (acc_trace),
        .trace_valid   (trace_valid),
        .trace_overrun (trace_overrun),
        .mask_ready    (mask_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_center(input int r, input int c);
        load_center = 1'b1;
        center_row  = 8'(r);
        center_col  = 9'(c);
        tick();
        load_center = 1'b0;
    endtask

    // kind 0: all ones; kind 1: checkerboard (dr+dc)&1. Optionally drive a pixel alongside.
    task automatic load_mask(input int start, input int n, input int kind, input bit with_pix);
        for (int i = start; i < start + n; i++) begin
            load_contour = 1'b1;
            contour_data = (kind == 0) ? 1'b1 : 1'(((i / 16) + (i % 16)) & 1);
            if (with_pix) begin
                pix_valid = 1'b1;
                pix_row   = center_row;
                pix_col   = center_col;
                pix_data  = 8'd50;
            end
            tick();
        end
        load_contour = 1'b0;
        pix_valid    = 1'b0;
    endtask

    task automatic stream(input int r0, input int r1, input int c0, input int c1, input int d);
        for (int r = r0; r <= r1; r++) begin
            for (int c = c0; c <= c1; c++) begin
                pix_valid = 1'b1;
                pix_row   = 8'(r);
                pix_col   = 9'(c);
                pix_data  = 8'(d);
                tick();
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
    endtask

    task automatic do_store();
        store_trace = 1'b1;
        tick();
        store_trace = 1'b0;
    endtask

    initial begin
        tick();
        check("reset_acc", acc_trace, 16'd0);
        check("reset_valid", 16'(trace_valid), 16'd0);
        check("reset_overrun", 16'(trace_overrun), 16'd0);
        check("reset_ready", 16'(mask_ready), 16'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // All-ones mask, full window of ones
        set_center(20, 30);
        load_mask(0, 255, 0, 1'b0);
        check("ready_at_255", 16'(mask_ready), 16'd0);
        load_mask(255, 1, 0, 1'b0);
        check("ready_at_256", 16'(mask_ready), 16'd1);
        stream(12, 27, 22, 37, 1);
        end_frame();
        check("fill_acc", acc_trace, 16'd256);
        check("fill_valid", 16'(trace_valid), 16'd1);
        do_store();
        check("store_valid", 16'(trace_valid), 16'd0);
        check("store_acc_hold", acc_trace, 16'd256);

        // Checkerboard mask over a full frame
        set_center(20, 30);
        load_mask(0, 256, 1, 1'b0);
        stream(0, 63, 0, 127, 255);
        end_frame();
        check("checker_acc", acc_trace, 16'd32640);
        check("checker_valid", 16'(trace_valid), 16'd1);
        check("checker_no_ovr", 16'(trace_overrun), 16'd0);
        do_store();

        // Edge clip near the frame origin
        set_center(3, 2);
        load_mask(0, 256, 0, 1'b0);
        stream(0, 63, 0, 127, 10);
        end_frame();
        check("edge_acc", acc_trace, 16'd1100);

        // Collision: pixels at N-1 and N with frame_end at N, store during the latch cycle
        pix_valid = 1'b1; pix_row = 8'd3; pix_col = 9'd2; pix_data = 8'd9;
        tick();
        pix_data = 8'd4; frame_end = 1'b1;
        tick();
        pix_valid = 1'b0; frame_end = 1'b0; store_trace = 1'b1;
        tick();
        store_trace = 1'b0;
        check("collide_acc", acc_trace, 16'd13);
        check("collide_valid", 16'(trace_valid), 16'd1);
        check("collide_no_ovr", 16'(trace_overrun), 16'd0);

        // Second result overwrites an unconsumed one
        stream(3, 3, 2, 2, 7);
        end_frame();
        check("ovr_acc", acc_trace, 16'd7);
        check("ovr_flag", 16'(trace_overrun), 16'd1);
        do_store();

        // Restart mid-load; pixels during LOAD are dropped
        set_center(20, 30);
        load_mask(0, 100, 0, 1'b1);
        check("restart_100", 16'(mask_ready), 16'd0);
        set_center(20, 30);
        load_mask(0, 255, 0, 1'b1);
        check("restart_255", 16'(mask_ready), 16'd0);
        load_mask(255, 1, 0, 1'b0);
        check("restart_256", 16'(mask_ready), 16'd1);
        stream(20, 20, 30, 30, 3);
        end_frame();
        check("restart_acc", acc_trace, 16'd3);

        // Async reset mid-accumulation
        stream(20, 20, 30, 35, 5);
        pix_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_acc", acc_trace, 16'd0);
        check("arst_valid", 16'(trace_valid), 16'd0);
        check("arst_overrun", 16'(trace_overrun), 16'd0);
        check("arst_ready", 16'(mask_ready), 16'd0);
        tick();
        pix_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        pix_valid = 1'b1; pix_row = 8'd20; pix_col = 9'd30; pix_data = 8'd77; frame_end = 1'b1;
        tick();
        pix_valid = 1'b0; frame_end = 1'b0;
        tick();
        check("idle_fe_acc", acc_trace, 16'd0);
        check("idle_fe_valid", 16'(trace_valid), 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tracer_trace_accum.md
# tracer_trace_accum

Per-ROI fluorescence trace accumulator in the CImgTracer datapath, directly upstream of the tracer store path. It captures the ROI center and the 16x16 contour mask streamed out by the tracer load controller. It then sums enhanced, downsampled frame pixels that fall under the mask and presents the 16-bit per-frame sum on `acc_trace` for the store controller to consume via `store_trace`.

## Interface
- WIN, 16, window side in pixels; mask holds WIN*WIN bits; fixed at 16
- PIX_W, 8, pixel width; WIN=16 and PIX_W=8 guarantee the sum fits 16 bits exactly
- s_axi_aclk  in  1  sole clock, rising edge
- s_axi_aresetn  in  1  asynchronous, active-low reset
- load_center  in  1  one-cycle strobe; latch center, restart mask load
- center_row  in  8  ROI center row (downsampled frame)
- center_col  in  9  ROI center column
- load_contour  in  1  one-cycle strobe; contour_data valid
- contour_data  in  1  next mask bit, raster order within window
- pix_valid  in  1  pixel strobe
- pix_row  in  8  row of current pixel
- pix_col  in  9  column of current pixel
- pix_data  in  8  enhanced pixel value, unsigned
- frame_end  in  1  strobe, coincident with or after the last pix_valid of a frame
- store_trace  in  1  consumer strobe; acknowledges acc_trace
- acc_trace  out  16  latched per-frame masked sum
- trace_valid  out  1  acc_trace holds an unconsumed result
- trace_overrun  out  1  sticky; a result was overwritten unconsumed
- mask_ready  out  1  high in ARMED

## Operation
- FSM states are IDLE, LOAD and ARMED. Reset enters IDLE.
- `load_center` takes the FSM from any state to LOAD:
  - latch center_row and center_col;
  - set mask pointer to 0, clear mask register and running sum;
  - leave acc_trace, trace_valid and trace_overrun unchanged.
- LOAD:
  - each `load_contour` writes contour_data to mask[ptr] and then increments ptr (ptr 0..255, index = dr*16+dc);
  - the write at ptr=255 moves the FSM to ARMED.
- `load_contour` in IDLE or ARMED is ignored; there is no pointer wrap.
- Window membership:
  - dr = pix_row − center_row + 8 and dc = pix_col − center_col + 8, computed as 10/11-bit signed;
  - a pixel is in the window iff 0 ≤ dr ≤ 15 and 0 ≤ dc ≤ 15;
  - near frame edges (center_row<8, etc.), negative results are excluded with no wrap.
- Accumulation happens only in ARMED:
  - sum += pix_data when the pixel is in the window and mask[dr*16+dc]=1;
  - sum is 16-bit unsigned and cannot exceed 256*255=65280, so there is no saturation logic;
  - pixels in IDLE or LOAD are dropped.
- frame_end, in any state, propagates through the same pipeline as the pixels:
  - at its output stage, acc_trace ← final sum (including pixels from the same cycle), trace_valid ← 1 and sum ← 0;
  - if trace_valid was already 1 and store_trace is not asserted in that cycle, trace_overrun ← 1;
  - frame_end outside ARMED latches a sum of 0.
- `store_trace` clears trace_valid; acc_trace holds its value.
- store_trace coinciding with a latch: the latch wins, trace_valid stays 1, no overrun.
- trace_overrun clears only on reset.

## Timing
- Reset values: acc_trace=0, trace_valid=0, trace_overrun=0, mask_ready=0, sum=0, mask=0, ptr=0, center=0.
- Pixel pipeline:
  - stage 1 (cycle N+1): register window test, mask index and pix_data;
  - stage 2 (cycle N+2): mask lookup and sum update.
- Pixel at cycle N is reflected in sum at N+2.
- frame_end at cycle N gives acc_trace/trace_valid at N+2, so a back-to-back last pixel at N−1 or N is included.
- mask_ready rises the cycle after the 256th load_contour.
- load_center at cycle N:
  - flushes both pipeline stages, so in-flight pixels and frame_end are discarded;
  - ptr=0 and mask_ready=0 take effect from N+1.
- store_trace takes effect in 1 cycle: trace_valid falls at N+1.
- Asynchronous reset mid-frame or mid-load: immediately return to reset values and IDLE; no partial result is latched.
- Maximum throughput is one pixel per clock; there is no backpressure.

## Test plan
- Mask fill: center (20,30), 256 contour bits all 1, then stream full window rows 12..27 × cols 22..37 with pix_data=1, then frame_end → acc_trace=256, trace_valid=1.
- Checkerboard mask (bit = (dr+dc)&1), all pixels=255, full 64x128 frame → acc_trace=128*255=32640; pixels outside the window contribute nothing.
- Edge clip: center (3,2), all-ones mask, pixels=10, frame covers rows 0..63 → only dr≥5, dc≥6 count → acc_trace=11*10*10=1100.
- Overrun and collision: two frame_end with no store_trace → trace_overrun=1, acc_trace = second sum. store_trace coincident with a third latch → trace_valid stays 1.
- Restart: load_center issued after 100 contour bits, then 256 fresh bits → mask_ready only after the fresh 256. Pixels during LOAD are ignored. A pixel 1 cycle before frame_end is included.
- Async reset asserted mid-accumulation → all outputs 0 within the same cycle; next frame_end without an ARMED mask → acc_trace=0.
